mcycle_unit: RTL and testbench

MCYCLE_UNIT -- requirements
Module: mcycle_unit

---
 rtl/mcycle_unit_pkg.sv | 18 +
 rtl/mcycle_step.sv | 36 +++
 rtl/mcycle_unit.sv | 112 +++++++++++
 tb/tb_mcycle_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// This package holds the FSM encoding, the operation codes and the iteration count.
package mcycle_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } mcycle_state_e;

  localparam logic MCOP_MUL = 1'b0;
  localparam logic MCOP_DIV = 1'b1;

  localparam int unsigned MCYCLE_ITERS = 32;
  localparam int unsigned CNT_W        = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MCYCLE_ITERS - 1);

endpackage

// File: rtl/mcycle_step.sv
// One iteration of the shared datapath: a right-shifting shift-add for multiply,
// or a left-shifting restoring shift-subtract for divide. The block is purely combinational.
module mcycle_step
  import mcycle_unit_pkg::*;
(
  input  logic        op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] b,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        fits;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : 33'd0);
    shifted = {hi, lo[31]};
    fits    = (shifted >= {1'b0, b});
    hi_next = sum[32:1];
    lo_next = {sum[0], lo[31:1]};
    if (op == MCOP_DIV) begin
      // A difference that fits is always below the divisor, so 32-bit wrap is exact.
      if (fits) begin
        hi_next = shifted[31:0] - b;
        lo_next = {lo[30:0], 1'b1};
      end else begin
        hi_next = shifted[31:0];
        lo_next = {lo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply (with optional accumulate and long result) and divide unit.
// An operation takes 32 iterations; the unit stalls the pipeline through Busy and flags results with Done.
module mcycle_unit
  import mcycle_unit_pkg::*;
(
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Start,
  input  logic          MCycleOp,
  input  logic          MCAdd,
  input  logic          MCLong,
  input  logic [31:0]   Operand1,
  input  logic [31:0]   Operand2,
  input  logic [31:0]   Operand3,
  output logic [31:0]   Result1,
  output logic [31:0]   Result2,
  output logic          Busy,
  output logic          Done,
  output mcycle_state_e State
);

  mcycle_state_e    state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             op_q, long_q;
  logic [31:0]      hi_q, lo_q, b_q;
  logic [31:0]      hi_next, lo_next;
  logic             load, step, finish;

  assign State = state;

  mcycle_step u_step (
    .op      (op_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .b       (b_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          Busy       = 1'b1;
          load       = 1'b1;
          state_next = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        Busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST_ITER) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        Done = 1'b1;
        if (Start) begin
          Busy       = 1'b1;
          load       = 1'b1;
          state_next = ST_COMPUTE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The accumulate addend is preloaded into the high word. It then shifts down
  // into the low word and is added into the product as the iterations run.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      op_q    <= 1'b0;
      long_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else if (load) begin
      cnt    <= '0;
      op_q   <= MCycleOp;
      long_q <= MCLong;
      lo_q   <= Operand1;
      b_q    <= Operand2;
      hi_q   <= (MCycleOp == MCOP_MUL && MCAdd) ? Operand3 : 32'd0;
    end else if (step) begin
      cnt  <= cnt + CNT_W'(1);
      hi_q <= hi_next;
      lo_q <= lo_next;
      if (finish) begin
        Result1 <= lo_next;
        Result2 <= (op_q == MCOP_MUL && !long_q) ? 32'd0 : hi_next;
      end
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: directed vector table, randomized operations against an
// arithmetic reference model, and hand-written reset / back-to-back / interference sequences.
module tb_mcycle_unit;
  import mcycle_unit_pkg::*;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Start;
  logic          MCycleOp, MCAdd, MCLong;
  logic [31:0]   Operand1, Operand2, Operand3;
  logic [31:0]   Result1, Result2;
  logic          Busy, Done;
  mcycle_state_e State;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic        op;
    logic        add;
    logic        lng;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vecs[8];

  mcycle_unit dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .MCAdd    (MCAdd),
    .MCLong   (MCLong),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Operand3 (Operand3),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done),
    .State    (State)
  );

  // Clock and reset
  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic, {Result2, Result1}
  function automatic logic [63:0] model(input logic op, input logic add, input logic lng,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    logic [63:0] p;
    if (op == MCOP_DIV) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    p = {32'd0, a} * {32'd0, b} + (add ? {32'd0, c} : 64'd0);
    if (!lng) p[63:32] = 32'd0;
    return p;
  endfunction

  // Driver: presents a request in the current cycle (cycle 0) and checks the stall.
  task automatic start_op(input logic op, input logic add, input logic lng,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [63:0] exp);
    MCycleOp = op;
    MCAdd    = add;
    MCLong   = lng;
    Operand1 = a;
    Operand2 = b;
    Operand3 = c;
    Start    = 1'b1;
    exp_q.push_back(exp);
    #1;
    check("busy_cycle0", {63'd0, Busy}, 64'd1);
  endtask

  // Waits (bounded) for Done. Operands are scrambled from cycle 1 on; at cycle
  // `disturb` (if nonzero), Start is also pulsed.
  task automatic wait_done(input int disturb);
    int          seen;
    logic        busy_ok;
    logic [63:0] exp;
    seen    = 0;
    busy_ok = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1 || cyc == disturb) begin
        MCycleOp = 1'($urandom_range(0, 1));
        MCAdd    = 1'($urandom_range(0, 1));
        MCLong   = 1'($urandom_range(0, 1));
        Operand1 = $urandom;
        Operand2 = $urandom;
        Operand3 = $urandom;
      end
      Start = (disturb != 0 && cyc == disturb);
      @(negedge CLK);
      if (Done) begin
        seen = cyc;
        break;
      end
      if (!Busy) busy_ok = 1'b0;
      @(posedge CLK); #1;
    end
    Start = 1'b0;
    #1;
    check("done_latency", 64'(seen), 64'd33);
    check("busy_cycles_1_32", {63'd0, busy_ok}, 64'd1);
    check("busy_in_done", {63'd0, Busy}, 64'd0);
    exp = exp_q.pop_front();
    check("result1", {32'd0, Result1}, {32'd0, exp[31:0]});
    check("result2", {32'd0, Result2}, {32'd0, exp[63:32]});
  endtask

  initial begin
    logic        op, add, lng;
    logic [31:0] a, b, c;

    vecs[0] = '{MCOP_MUL, 1'b0, 1'b0, 32'd7,          32'd6,          32'd0,  32'd42,         32'd0};
    vecs[1] = '{MCOP_MUL, 1'b0, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,  32'h0000_0001,  32'hFFFF_FFFE};
    vecs[2] = '{MCOP_MUL, 1'b1, 1'b0, 32'd3,          32'd5,          32'd10, 32'd25,         32'd0};
    vecs[3] = '{MCOP_MUL, 1'b1, 1'b1, 32'hFFFF_FFFF,  32'd2,          32'd2,  32'h0000_0000,  32'h0000_0002};
    vecs[4] = '{MCOP_DIV, 1'b0, 1'b0, 32'd100,        32'd7,          32'd0,  32'd14,         32'd2};
    vecs[5] = '{MCOP_DIV, 1'b0, 1'b0, 32'd100,        32'd0,          32'd0,  32'hFFFF_FFFF,  32'd100};
    vecs[6] = '{MCOP_MUL, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,  32'h0000_0001,  32'd0};
    vecs[7] = '{MCOP_DIV, 1'b1, 1'b1, 32'hDEAD_BEEF,  32'h10,         32'd9,  32'h0DEA_DBEE,  32'hF};

    Reset = 1'b1; Start = 1'b0; MCycleOp = 1'b0; MCAdd = 1'b0; MCLong = 1'b0;
    Operand1 = '0; Operand2 = '0; Operand3 = '0;
    repeat (2) @(negedge CLK);
    check("rst_result1", {32'd0, Result1}, 64'd0);
    check("rst_result2", {32'd0, Result2}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_state", 64'(State), 64'(ST_IDLE));
    #1 Reset = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      start_op(vecs[i].op, vecs[i].add, vecs[i].lng, vecs[i].a, vecs[i].b, vecs[i].c,
               {vecs[i].r2, vecs[i].r1});
      wait_done(0);
    end

    // Results hold in IDLE after Done
    @(posedge CLK); #1;
    @(negedge CLK);
    check("idle_state", 64'(State), 64'(ST_IDLE));
    check("idle_done", {63'd0, Done}, 64'd0);
    check("hold_result1", {32'd0, Result1}, {32'd0, vecs[7].r1});
    check("hold_result2", {32'd0, Result2}, {32'd0, vecs[7].r2});

    // Start pulse and operand changes mid-COMPUTE are ignored
    @(posedge CLK); #1;
    start_op(MCOP_MUL, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h55,
             model(MCOP_MUL, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h55));
    wait_done(5);

    // Start held in the DONE cycle: back-to-back operations
    @(posedge CLK); #1;
    start_op(MCOP_DIV, 1'b0, 1'b0, 32'd1000, 32'd33, 32'd0,
             model(MCOP_DIV, 1'b0, 1'b0, 32'd1000, 32'd33, 32'd0));
    wait_done(0);
    start_op(MCOP_MUL, 1'b0, 1'b1, 32'hABCD, 32'h1234, 32'd0,
             model(MCOP_MUL, 1'b0, 1'b1, 32'hABCD, 32'h1234, 32'd0));
    check("b2b_done_cycle", {63'd0, Done}, 64'd1);
    wait_done(0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      op  = 1'($urandom_range(0, 1));
      add = 1'($urandom_range(0, 1));
      lng = 1'($urandom_range(0, 1));
      a   = $urandom;
      c   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      @(posedge CLK); #1;
      start_op(op, add, lng, a, b, c, model(op, add, lng, a, b, c));
      wait_done(0);
    end

    // Reset asserted in cycle 10 of an operation
    @(posedge CLK); #1;
    start_op(MCOP_MUL, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0, 64'd0);
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1 Reset = 1'b1;
    #1;
    check("midrst_busy", {63'd0, Busy}, 64'd0);
    check("midrst_done", {63'd0, Done}, 64'd0);
    check("midrst_result1", {32'd0, Result1}, 64'd0);
    check("midrst_result2", {32'd0, Result2}, 64'd0);
    check("midrst_state", 64'(State), 64'(ST_IDLE));
    void'(exp_q.pop_front());
    @(negedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    check("post_rst_busy_idle", {63'd0, Busy}, 64'd0);
    check("post_rst_state", 64'(State), 64'(ST_IDLE));
    @(posedge CLK); #1;
    start_op(MCOP_DIV, 1'b0, 1'b0, 32'd12345, 32'd100, 32'd0,
             model(MCOP_DIV, 1'b0, 1'b0, 32'd12345, 32'd100, 32'd0));
    wait_done(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
